// File: rtl/hash_msg_padder_pkg.sv
// Shared types and constants for the hash message padder.
// Opcodes, padder FSM states and byte-lane placement helper.
package hash_msg_padder_pkg;

   typedef enum logic [1:0] {
      OPCODE_MD5     = 2'b00,
      OPCODE_SHA1    = 2'b01,
      OPCODE_SHA256  = 2'b10,
      OPCODE_RESERVE = 2'b11
   } opcode_def;

   typedef enum logic [1:0] {
      P_IDLE,
      P_READ,
      P_WAIT,
      P_EMIT
   } pad_state_def;

   localparam logic [7:0] PAD_BYTE = 8'h80;
   localparam int WORDS_PER_CHUNK = 16;

   // Bit-lane (in bytes from the LSB) that holds message byte k.
   function automatic logic [1:0] lane_pos(opcode_def op, logic [1:0] k);
      return (op == OPCODE_MD5) ? k : 2'd3 - k;
   endfunction

endpackage

// File: rtl/hash_msg_padder_word_gen.sv
// Combinational padded-word generator for word index idx.
// Also reports whether that word is sourced from message memory.
module hash_msg_padder_word_gen
   import hash_msg_padder_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic [LEN_W-1:0] idx,
   input  logic [LEN_W-1:0] q,
   input  logic [1:0]       r,
   input  logic [LEN_W-1:0] last_idx,
   input  logic [63:0]      len_bits,
   input  opcode_def        opcode,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      word,
   output logic             needs_mem
);

   logic       sha;
   logic [2:0] kb;

   assign sha = (opcode != OPCODE_MD5);

   always_comb begin
      word      = '0;
      needs_mem = 1'b0;
      kb        = '0;
      if (idx < q) begin
         word      = mem_rdata;
         needs_mem = 1'b1;
      end else if (idx == q) begin
         needs_mem = (r != 2'd0);
         for (int k = 0; k < 4; k++) begin
            kb = 3'(k);
            if (kb < {1'b0, r})
               word[{lane_pos(opcode, kb[1:0]), 3'b000} +: 8] =
                  mem_rdata[{lane_pos(opcode, kb[1:0]), 3'b000} +: 8];
            else if (kb == {1'b0, r})
               word[{lane_pos(opcode, kb[1:0]), 3'b000} +: 8] = PAD_BYTE;
         end
      end else if (idx == last_idx - LEN_W'(1)) begin
         word = sha ? len_bits[63:32] : len_bits[31:0];
      end else if (idx == last_idx) begin
         word = sha ? len_bits[31:0] : len_bits[63:32];
      end
   end

endmodule

// File: rtl/hash_msg_padder.sv
// Reads a byte-length message and streams MD5/SHA padded 32-bit words.
// Memory words take a read/wait/emit trip; generated words stream 1/cycle.
module hash_msg_padder
   import hash_msg_padder_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        opcode,
   input  logic [ADDR_W-1:0] msg_addr,
   input  logic [LEN_W-1:0]  msg_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       w_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              w_chunk_last,
   output logic              w_msg_last
);

   pad_state_def      state_q, state_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  q_q, q_d;
   logic [1:0]        r_q, r_d;
   logic [LEN_W-1:0]  last_q, last_d;
   logic [63:0]       len_bits_q, len_bits_d;
   opcode_def         op_q, op_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       w_data_q, w_data_d;
   logic              w_valid_q, w_valid_d;
   logic              chunk_last_q, chunk_last_d;
   logic              msg_last_q, msg_last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              rd_en_q, rd_en_d;

   logic [LEN_W:0]    len_plus;
   logic [LEN_W:0]    chunks_m1;
   logic [LEN_W-1:0]  in_last;
   logic [LEN_W-1:0]  gen_idx;
   logic [LEN_W-1:0]  gen_q;
   logic [1:0]        gen_r;
   logic [LEN_W-1:0]  gen_last;
   logic [63:0]       gen_len_bits;
   opcode_def         gen_op;
   logic [31:0]       gen_word;
   logic              gen_need;
   logic              gen_cl;
   logic              gen_ml;

   // Index of the final word: 16 * ((len + 8) / 64) + 15.
   assign len_plus  = {1'b0, msg_len} + (LEN_W+1)'(8);
   assign chunks_m1 = len_plus >> 6;
   assign in_last   = LEN_W'({chunks_m1, 4'hF});

   always_comb begin
      if (state_q == P_IDLE) begin
         gen_idx      = '0;
         gen_q        = LEN_W'(msg_len >> 2);
         gen_r        = msg_len[1:0];
         gen_last     = in_last;
         gen_len_bits = 64'({msg_len, 3'b000});
         gen_op       = opcode_def'(opcode);
      end else begin
         gen_idx      = (state_q == P_EMIT) ? idx_q + LEN_W'(1) : idx_q;
         gen_q        = q_q;
         gen_r        = r_q;
         gen_last     = last_q;
         gen_len_bits = len_bits_q;
         gen_op       = op_q;
      end
      gen_cl = (gen_idx[3:0] == 4'(WORDS_PER_CHUNK - 1));
      gen_ml = (gen_idx == gen_last);
   end

   hash_msg_padder_word_gen #(
      .LEN_W (LEN_W)
   ) u_word_gen (
      .idx       (gen_idx),
      .q         (gen_q),
      .r         (gen_r),
      .last_idx  (gen_last),
      .len_bits  (gen_len_bits),
      .opcode    (gen_op),
      .mem_rdata (mem_rdata),
      .word      (gen_word),
      .needs_mem (gen_need)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      q_d          = q_q;
      r_d          = r_q;
      last_d       = last_q;
      len_bits_d   = len_bits_q;
      op_d         = op_q;
      base_d       = base_q;
      w_data_d     = w_data_q;
      w_valid_d    = w_valid_q;
      chunk_last_d = chunk_last_q;
      msg_last_d   = msg_last_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      mem_addr_d   = mem_addr_q;
      rd_en_d      = 1'b0;
      unique case (state_q)
         P_IDLE: begin
            if (start) begin
               if (opcode_def'(opcode) == OPCODE_RESERVE) begin
                  err_d = 1'b1;
               end else begin
                  idx_d      = '0;
                  q_d        = gen_q;
                  r_d        = gen_r;
                  last_d     = gen_last;
                  len_bits_d = gen_len_bits;
                  op_d       = gen_op;
                  base_d     = msg_addr;
                  busy_d     = 1'b1;
                  if (gen_need) begin
                     state_d    = P_READ;
                     rd_en_d    = 1'b1;
                     mem_addr_d = msg_addr;
                  end else begin
                     state_d      = P_EMIT;
                     w_data_d     = gen_word;
                     w_valid_d    = 1'b1;
                     chunk_last_d = gen_cl;
                     msg_last_d   = gen_ml;
                  end
               end
            end
         end
         P_READ: begin
            state_d = P_WAIT;
         end
         P_WAIT: begin
            state_d      = P_EMIT;
            w_data_d     = gen_word;
            w_valid_d    = 1'b1;
            chunk_last_d = gen_cl;
            msg_last_d   = gen_ml;
         end
         P_EMIT: begin
            if (w_ready) begin
               if (idx_q == last_q) begin
                  state_d      = P_IDLE;
                  w_data_d     = '0;
                  w_valid_d    = 1'b0;
                  chunk_last_d = 1'b0;
                  msg_last_d   = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  idx_d = gen_idx;
                  if (gen_need) begin
                     state_d      = P_READ;
                     w_valid_d    = 1'b0;
                     chunk_last_d = 1'b0;
                     msg_last_d   = 1'b0;
                     rd_en_d      = 1'b1;
                     mem_addr_d   = base_q + gen_idx[ADDR_W-1:0];
                  end else begin
                     w_data_d     = gen_word;
                     chunk_last_d = gen_cl;
                     msg_last_d   = gen_ml;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= P_IDLE;
         idx_q        <= '0;
         q_q          <= '0;
         r_q          <= '0;
         last_q       <= '0;
         len_bits_q   <= '0;
         op_q         <= OPCODE_MD5;
         base_q       <= '0;
         w_data_q     <= '0;
         w_valid_q    <= 1'b0;
         chunk_last_q <= 1'b0;
         msg_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         mem_addr_q   <= '0;
         rd_en_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         q_q          <= q_d;
         r_q          <= r_d;
         last_q       <= last_d;
         len_bits_q   <= len_bits_d;
         op_q         <= op_d;
         base_q       <= base_d;
         w_data_q     <= w_data_d;
         w_valid_q    <= w_valid_d;
         chunk_last_q <= chunk_last_d;
         msg_last_q   <= msg_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         mem_addr_q   <= mem_addr_d;
         rd_en_q      <= rd_en_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign mem_addr     = mem_addr_q;
   assign mem_rd_en    = rd_en_q;
   assign w_data       = w_data_q;
   assign w_valid      = w_valid_q;
   assign w_chunk_last = chunk_last_q;
   assign w_msg_last   = msg_last_q;

endmodule

// File: tb/tb_hash_msg_padder.sv
// Directed testbench for hash_msg_padder.
// Simple registered memory model; scenarios run as sequential tasks.
module tb_hash_msg_padder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  opcode;
   logic [15:0] msg_addr;
   logic [31:0] msg_len;
   logic        busy, done, err;
   logic [15:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic [31:0] w_data;
   logic        w_valid;
   logic        w_ready;
   logic        w_chunk_last;
   logic        w_msg_last;

   logic [31:0] mem [0:65535];

   int checks = 0;
   int errors = 0;

   logic [31:0] wq[$];
   bit          clq[$];
   bit          mlq[$];
   int          nrd;
   int          ndone;
   int          rd_first;
   int          valid_first;
   int          hold_bad;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_rd_en) mem_rdata <= mem[mem_addr];

   hash_msg_padder #(
      .ADDR_W (16),
      .LEN_W  (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .opcode       (opcode),
      .msg_addr     (msg_addr),
      .msg_len      (msg_len),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_rdata    (mem_rdata),
      .w_data       (w_data),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .w_chunk_last (w_chunk_last),
      .w_msg_last   (w_msg_last)
   );

   function automatic logic [31:0] pat(input int k);
      return 32'h5A00BEEF | (32'(k) << 16);
   endfunction

   // Starts one message and records every accepted word until done.
   task automatic drive_msg(input logic [1:0] op, input logic [15:0] a,
                            input logic [31:0] len, input bit toggle,
                            input int budget);
      bit          fin;
      bit          stall_prev;
      logic [31:0] hd;
      bit          hcl, hml;
      wq.delete(); clq.delete(); mlq.delete();
      nrd = 0; ndone = 0; rd_first = -1; valid_first = -1; hold_bad = 0;
      fin = 0; stall_prev = 0; hd = '0; hcl = 0; hml = 0;
      start = 1'b1; opcode = op; msg_addr = a; msg_len = len;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= budget && !fin; c++) begin
         w_ready = toggle ? ((c % 3) != 0) : 1'b1;
         if (mem_rd_en) begin
            nrd++;
            if (rd_first < 0) rd_first = c;
         end
         if (w_valid && valid_first < 0) valid_first = c;
         if (stall_prev &&
             (w_valid !== 1'b1 || w_data !== hd ||
              w_chunk_last !== hcl || w_msg_last !== hml))
            hold_bad++;
         stall_prev = w_valid && !w_ready;
         hd = w_data; hcl = w_chunk_last; hml = w_msg_last;
         if (w_valid && w_ready) begin
            wq.push_back(w_data);
            clq.push_back(w_chunk_last);
            mlq.push_back(w_msg_last);
         end
         if (done) begin
            ndone++;
            fin = 1;
         end
         if (!fin) begin
            @(posedge clk); #1;
         end
      end
      w_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; opcode = 2'b00;
      msg_addr = '0; msg_len = '0; w_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err, mem_rd_en, w_valid, w_chunk_last, w_msg_last}
          !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=0000000",
                  {busy, done, err, mem_rd_en, w_valid, w_chunk_last, w_msg_last});
      end
      checks++;
      if (w_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_w_data got=%h exp=00000000", w_data);
      end
      checks++;
      if (mem_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_sha256_empty;
      logic [31:0] exp;
      drive_msg(2'b10, 16'h0000, 32'd0, 1'b0, 100);
      checks++;
      if (wq.size() !== 16) begin
         errors++;
         $display("FAIL e0_count got=%0d exp=16", wq.size());
      end
      checks++;
      if (ndone !== 1 || nrd !== 0) begin
         errors++;
         $display("FAIL e0_done_rd got=%0d/%0d exp=1/0", ndone, nrd);
      end
      for (int i = 0; i < wq.size() && i < 16; i++) begin
         exp = (i == 0) ? 32'h80000000 : 32'h0;
         checks++;
         if (wq[i] !== exp || clq[i] !== (i == 15) || mlq[i] !== (i == 15)) begin
            errors++;
            $display("FAIL e0_word%0d got=%h/%b/%b exp=%h/%b/%b",
                     i, wq[i], clq[i], mlq[i], exp, i == 15, i == 15);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL e0_busy_after got=%b exp=0", busy);
      end
   endtask

   task automatic test_sha1_abc;
      mem[16'h0020] = 32'h616263FF;
      drive_msg(2'b01, 16'h0020, 32'd3, 1'b0, 100);
      checks++;
      if (wq.size() !== 16) begin
         errors++;
         $display("FAIL s1_count got=%0d exp=16", wq.size());
      end else begin
         checks++;
         if (wq[0] !== 32'h61626380) begin
            errors++;
            $display("FAIL s1_word0 got=%h exp=61626380", wq[0]);
         end
         checks++;
         if (wq[14] !== 32'h0 || wq[15] !== 32'h18) begin
            errors++;
            $display("FAIL s1_len got=%h,%h exp=00000000,00000018",
                     wq[14], wq[15]);
         end
      end
      checks++;
      if (rd_first !== 1 || valid_first !== 3 || nrd !== 1) begin
         errors++;
         $display("FAIL s1_latency got=rd%0d/v%0d/n%0d exp=rd1/v3/n1",
                  rd_first, valid_first, nrd);
      end
   endtask

   task automatic test_md5_abc;
      mem[16'h0030] = 32'hFF636261;
      drive_msg(2'b00, 16'h0030, 32'd3, 1'b0, 100);
      checks++;
      if (wq.size() !== 16) begin
         errors++;
         $display("FAIL m5_count got=%0d exp=16", wq.size());
      end else begin
         checks++;
         if (wq[0] !== 32'h80636261) begin
            errors++;
            $display("FAIL m5_word0 got=%h exp=80636261", wq[0]);
         end
         checks++;
         if (wq[14] !== 32'h18 || wq[15] !== 32'h0) begin
            errors++;
            $display("FAIL m5_len got=%h,%h exp=00000018,00000000",
                     wq[14], wq[15]);
         end
      end
   endtask

   task automatic test_two_chunk;
      logic [31:0] exp;
      for (int k = 0; k < 14; k++) mem[16'h0100 + 16'(k)] = pat(k);
      drive_msg(2'b10, 16'h0100, 32'd56, 1'b0, 400);
      checks++;
      if (wq.size() !== 32 || nrd !== 14) begin
         errors++;
         $display("FAIL l56_count got=%0d/%0d exp=32/14", wq.size(), nrd);
      end
      for (int i = 0; i < wq.size() && i < 32; i++) begin
         if (i < 14)       exp = pat(i);
         else if (i == 14) exp = 32'h80000000;
         else if (i == 31) exp = 32'h000001C0;
         else              exp = 32'h0;
         checks++;
         if (wq[i] !== exp || clq[i] !== (i % 16 == 15) ||
             mlq[i] !== (i == 31)) begin
            errors++;
            $display("FAIL l56_word%0d got=%h/%b/%b exp=%h/%b/%b", i, wq[i],
                     clq[i], mlq[i], exp, i % 16 == 15, i == 31);
         end
      end
   endtask

   task automatic test_len55_wrap;
      for (int k = 0; k < 14; k++) mem[16'hFFF8 + 16'(k)] = pat(k);
      drive_msg(2'b10, 16'hFFF8, 32'd55, 1'b0, 200);
      checks++;
      if (wq.size() !== 16 || nrd !== 14) begin
         errors++;
         $display("FAIL l55_count got=%0d/%0d exp=16/14", wq.size(), nrd);
      end else begin
         checks++;
         if (wq[12] !== pat(12)) begin
            errors++;
            $display("FAIL l55_word12 got=%h exp=%h", wq[12], pat(12));
         end
         checks++;
         if (wq[13] !== 32'h5A0DBE80) begin
            errors++;
            $display("FAIL l55_word13 got=%h exp=5a0dbe80", wq[13]);
         end
         checks++;
         if (wq[14] !== 32'h0 || wq[15] !== 32'h1B8 || mlq[15] !== 1'b1) begin
            errors++;
            $display("FAIL l55_len got=%h,%h,%b exp=00000000,000001b8,1",
                     wq[14], wq[15], mlq[15]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp;
      mem[16'h0040] = 32'h01020304;
      mem[16'h0041] = 32'h05060708;
      drive_msg(2'b10, 16'h0040, 32'd5, 1'b1, 300);
      checks++;
      if (wq.size() !== 16 || ndone !== 1) begin
         errors++;
         $display("FAIL bp_count got=%0d/%0d exp=16/1", wq.size(), ndone);
      end
      checks++;
      if (hold_bad !== 0) begin
         errors++;
         $display("FAIL bp_hold got=%0d exp=0", hold_bad);
      end
      for (int i = 0; i < wq.size() && i < 16; i++) begin
         if (i == 0)       exp = 32'h01020304;
         else if (i == 1)  exp = 32'h05800000;
         else if (i == 15) exp = 32'h00000028;
         else              exp = 32'h0;
         checks++;
         if (wq[i] !== exp) begin
            errors++;
            $display("FAIL bp_word%0d got=%h exp=%h", i, wq[i], exp);
         end
      end
   endtask

   task automatic test_reserve;
      int bad;
      start = 1'b1; opcode = 2'b11; msg_addr = 16'h0; msg_len = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({err, busy, w_valid} !== 3'b100) begin
         errors++;
         $display("FAIL rsv_pulse got=%b exp=100", {err, busy, w_valid});
      end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (err || busy || w_valid || mem_rd_en) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL rsv_quiet got=%0d exp=0", bad);
      end
   endtask

   task automatic test_reset_mid;
      int bad;
      start = 1'b1; opcode = 2'b10; msg_addr = 16'h0; msg_len = 32'd0;
      w_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      checks++;
      if (w_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rm_running got=%b%b exp=11", w_valid, busy);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({busy, done, err, mem_rd_en, w_valid, w_chunk_last, w_msg_last}
          !== 7'b0 || w_data !== 32'h0) begin
         errors++;
         $display("FAIL rm_cleared got=%b/%h exp=0000000/00000000",
                  {busy, done, err, mem_rd_en, w_valid, w_chunk_last, w_msg_last},
                  w_data);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done || w_valid) bad++;
      end
      w_ready = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL rm_no_done got=%0d exp=0", bad);
      end
      mem[16'h0020] = 32'h616263FF;
      drive_msg(2'b01, 16'h0020, 32'd3, 1'b0, 100);
      checks++;
      if (wq.size() !== 16 || ndone !== 1) begin
         errors++;
         $display("FAIL rm_restart_count got=%0d/%0d exp=16/1", wq.size(), ndone);
      end else begin
         checks++;
         if (wq[0] !== 32'h61626380 || wq[15] !== 32'h18) begin
            errors++;
            $display("FAIL rm_restart_words got=%h,%h exp=61626380,00000018",
                     wq[0], wq[15]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sha256_empty();
      test_sha1_abc();
      test_md5_abc();
      test_two_chunk();
      test_len55_wrap();
      test_backpressure();
      test_reserve();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hash_msg_padder.md
Name: hash_msg_padder

Overview:
- Upstream feeder for the hash core: reads a byte-length message from word-addressed message memory and emits a stream of 32-bit words, 16 per 512-bit chunk.
- Appends the standard padding for MD5, SHA-1 and SHA-256: a 0x80 byte, zero fill, and the 64-bit bit-length.
- Flags the last word of each chunk and of the message so the hash core can sequence its precompute / kernel / epilogue / chunk-done phases.

Parameters:
ADDR_W, 16, message memory word-address width
LEN_W, 32, message byte-length width (max 61)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in P_IDLE
opcode  in  2  opcode_def; sampled with start
msg_addr  in  ADDR_W  word address of message byte 0; sampled with start
msg_len  in  LEN_W  message length in bytes; sampled with start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final word handshake
err  out  1  one-cycle pulse when start carries OPCODE_RESERVE
mem_addr  out  ADDR_W  read address
mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle
mem_rdata  in  32  memory read data, already in the algorithm's lane order
w_data  out  32  padded message word
w_valid  out  1  w_data valid
w_ready  in  1  hash core accepts the word; transfer occurs when w_valid && w_ready
w_chunk_last  out  1  current word is word 15 of a chunk
w_msg_last  out  1  current word is the last word of the message

Behaviour:
- Reset: all outputs 0; state P_IDLE; internal counters 0. Reset mid-operation aborts at the next edge with no done pulse.
- Byte lanes:
  - SHA (opcodes 01, 10): byte k of a word sits at bits [31-8k -: 8].
  - MD5 (opcode 00): byte k sits at bits [8k+7 : 8k].
- Sizes:
  - Chunk count N = (msg_len + 8) / 64 + 1.
  - Total words T = 16N.
  - Word index i runs 0..T-1.
  - q = msg_len / 4; r = msg_len % 4; L = {msg_len, 3'b0}, zero-extended to 64 bits.
- Word i content:
  - i < q: mem_rdata unchanged.
  - i == q, r != 0: mem_rdata with lanes >= r cleared and lane r = 0x80.
  - i == q, r == 0: 0x80 in lane 0, zeros elsewhere; no memory read.
  - q < i < T-2: 0.
  - i == T-2: SHA L[63:32]; MD5 L[31:0].
  - i == T-1: SHA L[31:0]; MD5 L[63:32].
  - i == q always lies below T-2, because a 0x80 byte never collides with the length field.
- FSM (pad_state_def):
  - P_IDLE: on start with a valid opcode, latch the inputs, set i = 0, and go to P_READ if word 0 needs memory, else P_EMIT with the generated word.
  - P_IDLE, start with OPCODE_RESERVE: pulse err, stay in P_IDLE.
  - P_READ: mem_rd_en = 1, mem_addr = msg_addr + i (wraps modulo 2^ADDR_W), then go to P_WAIT.
  - P_WAIT: capture mem_rdata, apply masking, register the result into w_data, then go to P_EMIT.
  - P_EMIT: w_valid = 1; w_data, w_chunk_last and w_msg_last are held stable until the handshake.
  - On handshake at i == T-1: go to P_IDLE with done = 1 for one cycle.
  - On any other handshake: i++, then go to P_READ if the new i needs memory, else stay in P_EMIT with the new generated word (back-to-back, 1 word/cycle).
- Latency:
  - start at cycle 0 with msg_len > 0: mem_rd_en at cycle 1, w_valid at cycle 3.
  - Memory-sourced words: 3 cycles per word with w_ready held high.
  - Generated words: 1 cycle per word with w_ready held high.
- Flags:
  - w_chunk_last = (i % 16 == 15).
  - w_msg_last = (i == T-1).
- start while busy is ignored. w_ready outside P_EMIT is ignored.

Decomposition:
- Shared package additions: pad_state_def enum {P_IDLE, P_READ, P_WAIT, P_EMIT}; constant PAD_BYTE = 8'h80; constant WORDS_PER_CHUNK = 16.
- The opcode enum is reused from the shared package.
- One natural sub-module, pad_word_gen: combinational; takes i, q, r, L, opcode and mem_rdata and produces the padded word and a needs-memory flag.

Test Plan:
- SHA-256, len 0: 16 words; word0 = 0x80000000, words 1..15 = 0; w_chunk_last and w_msg_last on word 15; no mem_rd_en; done pulse after word 15.
- SHA-1 "abc", mem word0 = 0x616263FF: word0 = 0x61626380, word15 = 0x00000018, word14 = 0.
- MD5 "abc", mem word0 = 0xFF636261: word0 = 0x80636261, word14 = 0x00000018, word15 = 0.
- SHA-256, len 56 (N = 2, T = 32): word14 = 0x80000000; w_chunk_last on words 15 and 31; word31 = 0x000001C0. SHA-256, len 55 (N = 1): word13 = mem word13 & 0xFFFFFF00 | 0x80.
- Backpressure: w_ready toggling 0/1 mid-stream; w_data and flags hold while stalled; no duplicated or dropped words (total 16N).
- OPCODE_RESERVE start: err pulse, busy stays 0, no w_valid. Separately, reset asserted at word 5: all outputs 0 next cycle, no done, and a new start runs cleanly.
